vmem_sequencer: RTL and testbench

Multi-cycle sequencer placed between the MEM stage and the single-port, element-wide data memory. It serializes one vector load or vector store into LANES element accesses and holds the pipeline stalled while it runs. On a load, it assembles the returned elements into one vector for write-back. Scalar memory operations bypass this block.

---
 rtl/vmem_sequencer_if.sv | 45 ++++
 rtl/vmem_sequencer.sv | 135 +++++++++++++
 tb/tb_vmem_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_sequencer_if.sv
// Bus bundle between the MEM stage, the vector memory sequencer and the
// element-wide data memory. The slave modport is the sequencer's view; the
// master modport is the pipeline plus memory side that surrounds it.
// The optional stride signal exists only when VMEM_SEQ_STRIDE_EN is defined.
interface vmem_sequencer_if #(
   parameter int LANES  = 4,
   parameter int ELEM_W = 8,
   parameter int ADDR_W = 16
);
   logic                    start;
   logic                    mem_write;
   logic [ADDR_W-1:0]       base_addr;
   logic [LANES*ELEM_W-1:0] wdata;
   logic                    flush;
`ifdef VMEM_SEQ_STRIDE_EN
   logic [ADDR_W-1:0]       stride;
`endif
   logic                    busy;
   logic                    done;
   logic [LANES*ELEM_W-1:0] rdata;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [ELEM_W-1:0]       mem_wdata;
   logic                    mem_ack;
   logic [ELEM_W-1:0]       mem_rdata;

   modport slave (
      input  start, mem_write, base_addr, wdata, flush,
`ifdef VMEM_SEQ_STRIDE_EN
      input  stride,
`endif
      input  mem_ack, mem_rdata,
      output busy, done, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output start, mem_write, base_addr, wdata, flush,
`ifdef VMEM_SEQ_STRIDE_EN
      output stride,
`endif
      output mem_ack, mem_rdata,
      input  busy, done, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vmem_sequencer.sv
// Vector memory sequencer: serializes one vector load/store into LANES
// element accesses on a single-port memory, stalling the pipeline meanwhile.
// Optional feature macro: VMEM_SEQ_STRIDE_EN (adds a strided address walk;
// without it the element stride is fixed at 1).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; op, base, wdata latched on accept
// S_ACCESS | one element access per acked cycle, idx walks 0..LANES-1
// S_FIN    | one-cycle done pulse, busy low, then back to S_IDLE
module vmem_sequencer #(
   parameter int LANES  = 4,
   parameter int ELEM_W = 8,
   parameter int ADDR_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   vmem_sequencer_if.slave bus
);
   localparam int IDX_W = $clog2(LANES);
   localparam int VEC_W = LANES * ELEM_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_FIN    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q;
   logic [VEC_W-1:0]  wdata_q;
   logic [VEC_W-1:0]  shadow_q, shadow_d;
   logic [VEC_W-1:0]  rdata_q, rdata_d;
   logic [ADDR_W-1:0] step;
   logic              in_access;
   logic              accept;
   logic              last_lane;

`ifdef VMEM_SEQ_STRIDE_EN
   logic [ADDR_W-1:0] stride_q;

   // Stride is captured with the op so the pipeline may move on meanwhile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stride_q <= '0;
      else if (accept)
         stride_q <= bus.stride;
   end

   assign step = stride_q;
`else
   assign step = ADDR_W'(1);
`endif

   assign in_access = (state_q == S_ACCESS);
   assign accept    = (state_q == S_IDLE) && bus.start;
   assign last_lane = (idx_q == IDX_W'(LANES - 1));

   // Next-state logic; the address is an accumulator so no multiplier is needed.
   // Load lanes collect in the shadow and reach rdata only on entry to S_FIN,
   // so a flushed load leaves the previous vector visible.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      shadow_d = shadow_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_ACCESS;
               idx_d   = '0;
               addr_d  = bus.base_addr;
            end
         end
         S_ACCESS: begin
            if (bus.mem_ack && !we_q)
               shadow_d[idx_q*ELEM_W +: ELEM_W] = bus.mem_rdata;
            if (bus.flush && !we_q) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else if (bus.mem_ack) begin
               if (last_lane) begin
                  state_d = S_FIN;
                  idx_d   = '0;
                  if (!we_q)
                     rdata_d = shadow_d;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  addr_d = addr_q + step;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         shadow_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
      end
   end

   // Op type and store vector are held for the whole operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= bus.mem_write;
         wdata_q <= bus.wdata;
      end
   end

   // busy is gated by rst_n so a start held during reset cannot stall the pipe.
   assign bus.busy      = rst_n & (in_access | accept);
   assign bus.done      = (state_q == S_FIN);
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = in_access;
   assign bus.mem_we    = in_access & we_q;
   assign bus.mem_addr  = in_access ? addr_q : '0;
   assign bus.mem_wdata = in_access ? wdata_q[idx_q*ELEM_W +: ELEM_W] : '0;
endmodule

// File: tb/tb_vmem_sequencer.sv
// Self-checking bench for vmem_sequencer: directed scenarios plus randomized
// ops checked against an address/data model computed from base, stride and lane.
module tb_vmem_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   vmem_sequencer_if #(.LANES(4), .ELEM_W(8), .ADDR_W(16)) bus ();

   vmem_sequencer #(.LANES(4), .ELEM_W(8), .ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_model [65536];
   assign bus.mem_rdata = mem_model[bus.mem_addr];

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] obs_addr [$];
   logic [7:0]  obs_wdata [$];
   logic        obs_we [$];
   int          ack_cycles [$];
   int          done_cyc, idle_cyc, stall_bad, busy_bad, req_cycles;
   logic        busy0, busy_fin;
   logic [31:0] rdata_done;
   logic [31:0] exp_rdata = 32'h0;
   logic [15:0] stride_drv = 16'd1;

   // Runs one op; start is asserted in cycle 0, cycles counted from the accept edge.
   task automatic do_op(input logic we, input logic [15:0] base, input logic [31:0] wd,
                        input int ack_pct, input int stall_lane, input int stall_len,
                        input int flush_cyc);
      int   stalls = 0;
      logic holding = 1'b0;
      logic [15:0] held = 16'h0;
      bit   fin = 1'b0;
      obs_addr.delete(); obs_wdata.delete(); obs_we.delete(); ack_cycles.delete();
      done_cyc = -2; idle_cyc = -1; stall_bad = 0; busy_bad = 0; req_cycles = 0;
      rdata_done = 32'hx; busy_fin = 1'bx;
      @(negedge clk);
      bus.start = 1'b1; bus.mem_write = we; bus.base_addr = base; bus.wdata = wd;
      bus.flush = 1'b0; bus.mem_ack = 1'b0;
`ifdef VMEM_SEQ_STRIDE_EN
      bus.stride = stride_drv;
`endif
      #1 busy0 = bus.busy;
      for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.mem_write = 1'($urandom);
         bus.base_addr = 16'($urandom); bus.wdata = $urandom;
`ifdef VMEM_SEQ_STRIDE_EN
         bus.stride = 16'($urandom);
`endif
         bus.flush = (cyc == flush_cyc);
         if (stall_lane == obs_addr.size() && stalls < stall_len) begin
            bus.mem_ack = 1'b0; stalls++;
         end else
            bus.mem_ack = ($urandom_range(99) < ack_pct);
         #1;
         if (bus.done) begin
            done_cyc = cyc; rdata_done = bus.rdata; busy_fin = bus.busy; fin = 1'b1;
         end else if (!bus.mem_req) begin
            idle_cyc = cyc; fin = 1'b1;
         end else begin
            req_cycles++;
            if (!bus.busy) busy_bad++;
            if (holding && bus.mem_addr !== held) stall_bad++;
            if (bus.mem_ack) begin
               obs_addr.push_back(bus.mem_addr); obs_wdata.push_back(bus.mem_wdata);
               obs_we.push_back(bus.mem_we); ack_cycles.push_back(cyc);
               if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
               holding = 1'b0;
            end else begin
               holding = 1'b1; held = bus.mem_addr;
            end
         end
      end
      bus.flush = 1'b0; bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.mem_write = 1'b0; bus.base_addr = 16'h0; bus.wdata = 32'h0;
      bus.flush = 1'b0; bus.mem_ack = 1'b0;
`ifdef VMEM_SEQ_STRIDE_EN
      bus.stride = 16'h1;
`endif
      repeat (3) @(negedge clk);
      n_checks++; if ({bus.busy, bus.done, bus.mem_req, bus.mem_we} !== 4'b0) begin n_errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus.busy, bus.done, bus.mem_req, bus.mem_we}); end
      n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 56'h0) begin n_errors++; $display("FAIL reset_data got %h exp 0", {bus.mem_addr, bus.mem_wdata, bus.rdata}); end
      bus.start = 1'b1; #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy_start got %b exp 0", bus.busy); end
      bus.start = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if ({bus.busy, bus.done, bus.mem_req, bus.rdata} !== 35'h0) begin n_errors++; $display("FAIL post_reset got %h exp 0", {bus.busy, bus.done, bus.mem_req, bus.rdata}); end
   endtask

   task automatic test_load_basic();
      mem_model[16'h10] = 8'h11; mem_model[16'h11] = 8'h22;
      mem_model[16'h12] = 8'h33; mem_model[16'h13] = 8'h44;
      stride_drv = 16'd1;
      do_op(1'b0, 16'h0010, 32'hA5A5A5A5, 100, -1, 0, -1);
      exp_rdata = 32'h44332211;
      n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL load_busy_c0 got %b exp 1", busy0); end
      n_checks++; if (done_cyc !== 5) begin n_errors++; $display("FAIL load_done_cyc got %0d exp 5", done_cyc); end
      n_checks++; if (busy_bad !== 0 || busy_fin !== 1'b0) begin n_errors++; $display("FAIL load_busy got bad=%0d fin=%b exp 0,0", busy_bad, busy_fin); end
      n_checks++; if (obs_addr.size() !== 4) begin n_errors++; $display("FAIL load_count got %0d exp 4", obs_addr.size()); end
      for (int k = 0; k < obs_addr.size(); k++) begin
         n_checks++; if (obs_addr[k] !== 16'h10 + 16'(k) || obs_we[k] !== 1'b0) begin n_errors++; $display("FAIL load_addr%0d got %h we %b exp %h we 0", k, obs_addr[k], obs_we[k], 16'h10 + 16'(k)); end
      end
      n_checks++; if (rdata_done !== exp_rdata) begin n_errors++; $display("FAIL load_rdata got %h exp %h", rdata_done, exp_rdata); end
      @(negedge clk); #1;
      n_checks++; if ({bus.mem_req, bus.done, bus.busy} !== 3'b0 || bus.rdata !== exp_rdata) begin n_errors++; $display("FAIL load_after got req/done/busy %b rdata %h exp 000 %h", {bus.mem_req, bus.done, bus.busy}, bus.rdata, exp_rdata); end
   endtask

   task automatic test_store_wrap();
      logic [15:0] ea [4];
      logic [7:0]  ed [4];
      ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      ed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      stride_drv = 16'd1;
      do_op(1'b1, 16'hFFFE, 32'hDDCCBBAA, 100, -1, 0, -1);
      n_checks++; if (done_cyc !== 5) begin n_errors++; $display("FAIL store_done_cyc got %0d exp 5", done_cyc); end
      n_checks++; if (obs_addr.size() !== 4) begin n_errors++; $display("FAIL store_count got %0d exp 4", obs_addr.size()); end
      for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
         n_checks++; if (obs_addr[k] !== ea[k] || obs_wdata[k] !== ed[k] || obs_we[k] !== 1'b1) begin n_errors++; $display("FAIL store_lane%0d got %h/%h we %b exp %h/%h we 1", k, obs_addr[k], obs_wdata[k], obs_we[k], ea[k], ed[k]); end
      end
      n_checks++; if (rdata_done !== exp_rdata) begin n_errors++; $display("FAIL store_rdata got %h exp %h", rdata_done, exp_rdata); end
   endtask

   task automatic test_stall();
      logic [15:0] base;
      logic [31:0] er;
      base = 16'($urandom);
      stride_drv = 16'd1;
      for (int k = 0; k < 4; k++) er[8*k +: 8] = mem_model[base + 16'(k)];
      do_op(1'b0, base, 32'h0, 100, 1, 3, -1);
      exp_rdata = er;
      n_checks++; if (done_cyc !== 8) begin n_errors++; $display("FAIL stall_done_cyc got %0d exp 8", done_cyc); end
      n_checks++; if (req_cycles !== 7 || stall_bad !== 0) begin n_errors++; $display("FAIL stall_hold got req=%0d moved=%0d exp 7,0", req_cycles, stall_bad); end
      n_checks++; if (obs_addr.size() < 2 || obs_addr[1] !== base + 16'd1) begin n_errors++; $display("FAIL stall_addr1 got size %0d exp addr %h", obs_addr.size(), base + 16'd1); end
      n_checks++; if (rdata_done !== er) begin n_errors++; $display("FAIL stall_rdata got %h exp %h", rdata_done, er); end
   endtask

   task automatic test_flush_load();
      mem_model[16'h30] = 8'h78; mem_model[16'h31] = 8'h56;
      mem_model[16'h32] = 8'h34; mem_model[16'h33] = 8'h12;
      stride_drv = 16'd1;
      do_op(1'b0, 16'h0030, 32'h0, 100, -1, 0, -1);
      exp_rdata = 32'h12345678;
      n_checks++; if (rdata_done !== exp_rdata) begin n_errors++; $display("FAIL flushld_prior got %h exp %h", rdata_done, exp_rdata); end
      do_op(1'b0, 16'h0040, 32'h0, 100, -1, 0, 3);
      n_checks++; if (idle_cyc !== 4 || done_cyc !== -2) begin n_errors++; $display("FAIL flushld_idle got idle=%0d done=%0d exp 4,-2", idle_cyc, done_cyc); end
      n_checks++; if (obs_addr.size() !== 3) begin n_errors++; $display("FAIL flushld_count got %0d exp 3", obs_addr.size()); end
      n_checks++; if (bus.rdata !== exp_rdata || bus.busy !== 1'b0) begin n_errors++; $display("FAIL flushld_rdata got %h busy %b exp %h busy 0", bus.rdata, bus.busy, exp_rdata); end
   endtask

   task automatic test_flush_store();
      logic [31:0] wd;
      wd = $urandom;
      stride_drv = 16'd1;
      do_op(1'b1, 16'h0050, wd, 100, -1, 0, 2);
      n_checks++; if (done_cyc !== 5 || obs_addr.size() !== 4) begin n_errors++; $display("FAIL flushst_done got cyc=%0d n=%0d exp 5,4", done_cyc, obs_addr.size()); end
      for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
         n_checks++; if (obs_addr[k] !== 16'h50 + 16'(k) || obs_wdata[k] !== wd[8*k +: 8]) begin n_errors++; $display("FAIL flushst_lane%0d got %h/%h exp %h/%h", k, obs_addr[k], obs_wdata[k], 16'h50 + 16'(k), wd[8*k +: 8]); end
      end
      n_checks++; if (rdata_done !== exp_rdata) begin n_errors++; $display("FAIL flushst_rdata got %h exp %h", rdata_done, exp_rdata); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] er;
      @(negedge clk);
      bus.start = 1'b1; bus.mem_write = 1'b0; bus.base_addr = 16'h0200; bus.flush = 1'b0; bus.mem_ack = 1'b0;
`ifdef VMEM_SEQ_STRIDE_EN
      bus.stride = 16'h1;
`endif
      @(negedge clk); bus.start = 1'b0; bus.mem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk); bus.mem_ack = 1'b0; #1;
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0202) begin n_errors++; $display("FAIL rstmid_pre got req %b addr %h exp 1 0202", bus.mem_req, bus.mem_addr); end
      #1 rst_n = 1'b0; #1;
      exp_rdata = 32'h0;
      n_checks++; if ({bus.mem_req, bus.busy, bus.done, bus.mem_we} !== 4'b0 || bus.rdata !== 32'h0 || bus.mem_addr !== 16'h0) begin n_errors++; $display("FAIL rstmid_async got ctrl %b rdata %h addr %h exp 0", {bus.mem_req, bus.busy, bus.done, bus.mem_we}, bus.rdata, bus.mem_addr); end
      @(negedge clk); rst_n = 1'b1;
      stride_drv = 16'd1;
      for (int k = 0; k < 4; k++) er[8*k +: 8] = mem_model[16'h0300 + 16'(k)];
      do_op(1'b0, 16'h0300, 32'h0, 100, -1, 0, -1);
      exp_rdata = er;
      n_checks++; if (done_cyc !== 5 || rdata_done !== er) begin n_errors++; $display("FAIL rstmid_after got cyc %0d rdata %h exp 5 %h", done_cyc, rdata_done, er); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] er;
      stride_drv = 16'd1;
      do_op(1'b1, 16'h0400, 32'hCAFEF00D, 100, -1, 0, -1);
      bus.start = 1'b1; bus.mem_write = 1'b0; bus.base_addr = 16'h0400; #1;
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin n_errors++; $display("FAIL b2b_fin got busy %b done %b exp 0 1", bus.busy, bus.done); end
      er = 32'hCAFEF00D;
      do_op(1'b0, 16'h0400, 32'h0, 100, -1, 0, -1);
      exp_rdata = er;
      n_checks++; if (done_cyc !== 5 || rdata_done !== er) begin n_errors++; $display("FAIL b2b_second got cyc %0d rdata %h exp 5 %h", done_cyc, rdata_done, er); end
   endtask

`ifdef VMEM_SEQ_STRIDE_EN
   task automatic test_stride();
      logic [15:0] ea [4];
      ea = '{16'h0100, 16'h0140, 16'h0180, 16'h01C0};
      stride_drv = 16'h0040;
      do_op(1'b0, 16'h0100, 32'h0, 100, -1, 0, -1);
      for (int k = 0; k < 4; k++) exp_rdata[8*k +: 8] = mem_model[ea[k]];
      n_checks++; if (obs_addr.size() !== 4) begin n_errors++; $display("FAIL stride_count got %0d exp 4", obs_addr.size()); end
      for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
         n_checks++; if (obs_addr[k] !== ea[k]) begin n_errors++; $display("FAIL stride_addr%0d got %h exp %h", k, obs_addr[k], ea[k]); end
      end
      n_checks++; if (rdata_done !== exp_rdata) begin n_errors++; $display("FAIL stride_rdata got %h exp %h", rdata_done, exp_rdata); end
   endtask
`endif

   task automatic test_random();
      logic        we;
      logic [15:0] base, a;
      logic [31:0] wd, er;
      int          pct, fl, n_exp;
      for (int t = 0; t < 40; t++) begin
         we = 1'($urandom); base = 16'($urandom); wd = $urandom;
         pct = $urandom_range(100, 30);
         fl = ($urandom_range(3) == 0) ? $urandom_range(4, 1) : -1;
`ifdef VMEM_SEQ_STRIDE_EN
         stride_drv = 16'($urandom);
`else
         stride_drv = 16'd1;
`endif
         for (int k = 0; k < 4; k++) begin
            a = base + 16'(k) * stride_drv;
            er[8*k +: 8] = mem_model[a];
         end
         do_op(we, base, wd, pct, -1, 0, fl);
         if (!we && fl > 0) begin
            n_exp = obs_addr.size();
            n_checks++; if (idle_cyc !== fl + 1 || done_cyc !== -2) begin n_errors++; $display("FAIL rnd%0d_flush got idle %0d done %0d exp %0d,-2", t, idle_cyc, done_cyc, fl + 1); end
            n_checks++; if (bus.rdata !== exp_rdata) begin n_errors++; $display("FAIL rnd%0d_flush_rdata got %h exp %h", t, bus.rdata, exp_rdata); end
         end else begin
            n_exp = 4;
            if (!we) exp_rdata = er;
            n_checks++; if (ack_cycles.size() !== 4 || done_cyc !== ack_cycles[ack_cycles.size() > 0 ? ack_cycles.size() - 1 : 0] + 1) begin n_errors++; $display("FAIL rnd%0d_done got cyc %0d acks %0d exp 4 acks then done", t, done_cyc, ack_cycles.size()); end
            n_checks++; if (rdata_done !== exp_rdata || busy_fin !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_rdata got %h busy %b exp %h busy 0", t, rdata_done, busy_fin, exp_rdata); end
            n_checks++; if (stall_bad !== 0 || busy_bad !== 0) begin n_errors++; $display("FAIL rnd%0d_hold got moved %0d busylow %0d exp 0,0", t, stall_bad, busy_bad); end
         end
         n_checks++; if (obs_addr.size() !== n_exp || n_exp > 4) begin n_errors++; $display("FAIL rnd%0d_count got %0d exp %0d", t, obs_addr.size(), n_exp); end
         for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            a = base + 16'(k) * stride_drv;
            n_checks++;
            if (obs_addr[k] !== a || obs_we[k] !== we || (we && obs_wdata[k] !== wd[8*k +: 8])) begin
               n_errors++; $display("FAIL rnd%0d_lane%0d got %h/%h we %b exp %h/%h we %b", t, k, obs_addr[k], obs_wdata[k], obs_we[k], a, wd[8*k +: 8], we);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
      test_reset();
      test_load_basic();
      test_store_wrap();
      test_stall();
      test_flush_load();
      test_flush_store();
      test_reset_mid();
      test_back_to_back();
`ifdef VMEM_SEQ_STRIDE_EN
      test_stride();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule
